// File: rtl/seg_scan_ctrl.sv
// Dual-digit seven-segment scan controller with frame-synchronous value update,
// inter-digit blanking and 16-level PWM brightness.
module seg_scan_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 6000,
  parameter int unsigned BLANK_CYCLES   = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic [7:0] value_i,
  input  logic       value_valid_i,
  output logic       value_ready_o,
  input  logic [3:0] brightness_i,
  output logic [6:0] seg_o,
  output logic       dig_sel_o,
  output logic       frame_o
);

  localparam int unsigned MAX_LEN = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN);
  localparam int unsigned PROD_W  = $clog2(SHOW_CYCLES) + 5;
  localparam int unsigned CMP_W   = CNT_W + 1;
  localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    BLANK_LO = 2'd0,
    SHOW_LO  = 2'd1,
    BLANK_HI = 2'd2,
    SHOW_HI  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             live_q, live_d;
  logic [7:0]       disp_q, disp_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       bright_q, bright_d;
  logic [6:0]       seg_q, seg_d;
  logic             dig_q, dig_d;
  logic             frame_q, frame_d;
  logic             ready_q, ready_d;

  logic [PROD_W-1:0] prod;
  logic [CMP_W-1:0]  on_len;
  logic [CNT_W-1:0]  last_cnt;
  logic              boundary;
  logic              xfer;
  logic              lit;
  logic [3:0]        nib;
  logic [6:0]        seg_raw;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Lit window length, full-width product before the divide by 16
  assign prod   = PROD_W'({1'b0, bright_q} + 5'd1) * PROD_W'(SHOW_CYCLES);
  assign on_len = CMP_W'(prod >> 4);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= BLANK_LO;
      cnt_q        <= '0;
      live_q       <= 1'b0;
      disp_q       <= 8'h00;
      pend_q       <= 8'h00;
      pend_valid_q <= 1'b0;
      bright_q     <= 4'hF;
      seg_q        <= SEG_OFF;
      dig_q        <= 1'b0;
      frame_q      <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      live_q       <= live_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      bright_q     <= bright_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_q      <= frame_d;
      ready_q      <= ready_d;
    end
  end

  // Next state, value path and registered outputs computed from the next state
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    live_d       = 1'b1;
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    bright_d     = bright_q;
    last_cnt     = CNT_W'(BLANK_CYCLES - 1);
    boundary     = live_q && (state_q == BLANK_LO) && (cnt_q == '0);
    xfer         = value_valid_i && ready_q;

    if (state_q == SHOW_LO || state_q == SHOW_HI) begin
      last_cnt = CNT_W'(SHOW_CYCLES - 1);
    end

    // The cycle right after reset release only arms the scan; it becomes the first boundary
    if (live_q) begin
      if (cnt_q == last_cnt) begin
        cnt_d = '0;
        case (state_q)
          BLANK_LO: state_d = SHOW_LO;
          SHOW_LO:  state_d = BLANK_HI;
          BLANK_HI: state_d = SHOW_HI;
          default:  state_d = BLANK_LO;
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (boundary) begin
      bright_d = brightness_i;
      if (pend_valid_q) begin
        disp_d       = pend_q;
        pend_valid_d = 1'b0;
      end
    end

    if (xfer) begin
      pend_d       = value_i;
      pend_valid_d = 1'b1;
    end

    nib     = (state_d == SHOW_HI) ? disp_d[7:4] : disp_d[3:0];
    lit     = ((state_d == SHOW_LO) || (state_d == SHOW_HI)) && ({1'b0, cnt_d} < on_len);
    seg_raw = lit ? glyph(nib) : 7'h00;
    seg_d   = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dig_d   = (state_d == BLANK_HI) || (state_d == SHOW_HI);
    frame_d = (state_d == BLANK_LO) && (cnt_d == '0);
    ready_d = !pend_valid_d;
  end

  assign seg_o         = seg_q;
  assign dig_sel_o     = dig_q;
  assign frame_o       = frame_q;
  assign value_ready_o = ready_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the dual-digit seven-segment PMOD on the iCEBreaker board. It takes the processor's 8-bit display value and time-multiplexes it as two hex digits onto 7 segment lines plus 1 digit-select line, replacing the direct byte-to-pin mapping at board top level. A frame-boundary handshake keeps a digit from showing half of one value and half of the next. Blanking intervals between digits prevent ghosting, and a 16-level PWM sets brightness.

## Interface
- SHOW_CYCLES, 6000: length of each digit's show phase in clk cycles (≥16).
- BLANK_CYCLES, 16: length of the blanking interval before each digit (≥1).
- SEG_ACTIVE_LOW, 1: when 1, seg_o is inverted (lit = 0).
- clk  in  1  system clock.
- reset_i  in  1  asynchronous, active-high reset.
- value_i  in  8  byte to display; [3:0] on digit 0, [7:4] on digit 1.
- value_valid_i  in  1  value_i is offered.
- value_ready_o  out  1  block can accept a value; a transfer occurs when valid && ready at a rising edge.
- brightness_i  in  4  PWM level, 0 = dimmest, 15 = full.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, seg_o[0] = a.
- dig_sel_o  out  1  0 = digit 0 (low nibble), 1 = digit 1 (high nibble).
- frame_o  out  1  one-cycle pulse on the first cycle of each frame.

## Operation
- States: BLANK_LO → SHOW_LO → BLANK_HI → SHOW_HI → BLANK_LO.
  - Each BLANK state lasts BLANK_CYCLES cycles.
  - Each SHOW state lasts SHOW_CYCLES cycles.
  - A single cycle counter runs 0..len-1 and resets to 0 on every state change.
- dig_sel_o is 0 in BLANK_LO and SHOW_LO, and 1 in BLANK_HI and SHOW_HI. It changes only on entry to a BLANK state, when the segments are already off.
- Segments are off in both BLANK states.
- In a SHOW state, segments show the hex glyph of the selected nibble while cnt < on_len; otherwise they are off.
  - on_len = ((bright_q + 1) * SHOW_CYCLES) >> 4.
  - The product is computed at full width (clog2(SHOW_CYCLES) + 5 bits) with no truncation before the shift.
- Glyphs (active-high gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- SEG_ACTIVE_LOW inverts all 7 bits, including the off pattern (off = 7F).
- Value path: a single pending register plus a valid flag.
  - value_ready_o = !pending_valid.
  - A transfer stores value_i into pending and sets pending_valid.
- Frame boundary is the first cycle of BLANK_LO (cnt == 0). In that cycle:
  - frame_o = 1.
  - bright_q <= brightness_i.
  - If pending_valid: disp_q <= pending and pending_valid is cleared.
- A transfer in the boundary cycle, with pending empty, lands in pending and is shown from the next frame.
- With pending full at a boundary: ready is low that cycle and rises the following cycle.
- brightness_i changes mid-frame have no effect until the next boundary.
- Outputs depend only on registered state. There is no combinational path from any input to any output.

## Timing
- Frame length = 2 × (BLANK_CYCLES + SHOW_CYCLES) cycles; the defaults give about 1 kHz at 12 MHz.
- Reset values:
  - state = BLANK_LO, cnt = 0, disp_q = 00, pending_valid = 0, bright_q = F.
  - seg_o = off, dig_sel_o = 0, value_ready_o = 1, frame_o = 0.
- The first cycle after reset release is a frame boundary: frame_o = 1.
- Transfers attempted while reset_i is high are ignored.
- Reset asserted mid-frame returns all state to reset values immediately (asynchronous). A pending value is discarded.
- Latency from a transfer to visible segments: up to one frame plus BLANK_CYCLES for digit 0.

## Test plan
- Parameters SHOW_CYCLES=32, BLANK_CYCLES=4, SEG_ACTIVE_LOW=0 (frame = 72 cycles).
- Reset release, no input → frame_o every 72 cycles; dig_sel_o 0 for 36 cycles then 1 for 36; seg_o = 3F during show phases, 00 in blanks.
- Transfer A5 at cycle 10, brightness 15 → ready low from cycle 11 until 1 cycle after the next boundary; next frame digit 0 shows 6D for all 32 show cycles, digit 1 shows 77.
- Brightness 7 → 16 lit cycles then 16 off per show phase; brightness 0 → 2 lit cycles; change at mid-frame applied only from the next frame_o.
- Back-to-back valid with 12 then 34 → 12 accepted, 34 stalled (ready=0) until the boundary; frames show 12 then 34; no frame shows mixed nibbles.
- Transfer offered exactly on the boundary cycle with pending empty → accepted; displayed one frame later.
- Assert reset_i mid SHOW_HI with a pending value → seg_o off and dig_sel_o = 0 immediately; after release the display shows 00 and ready = 1.
